cpu_ctrl_fsm: RTL and testbench
===============================

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter USE_MEM_READY, default 1; when 1, memory states wait on mem_ready; when 0, mem_ready is ignored and treated as 1.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  in  7  instruction opcode, inst[6:0].
REQ-005 SHALL have port funct3  in  3  instruction funct3.
REQ-006 SHALL have port funct7  in  7  instruction funct7.
REQ-007 SHALL have ports zf, sf, of, cf  in  1 each  ALU flags for the current cycle's operation; cf=1 means unsigned A<B on subtract.
REQ-008 SHALL have port mem_ready  in  1  memory access completes this cycle.
REQ-009 SHALL have ports pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables; datapath captures pc_old together with ir_write.
REQ-010 SHALL have port pc_sel  out  2  PC source: 00 PC+4, 01 ALU result, 10 ALU result & ~1.
REQ-011 SHALL have port wb_sel  out  2  register write source: 00 alu_out register, 01 memory data, 10 PC (already pc_old+4).
REQ-012 SHALL have ports alu_a_sel, alu_b_sel  out  2 each  A: 00 rs1, 01 pc_old, 10 zero; B: 00 rs2, 01 imm, 10 constant 4.
REQ-013 SHALL have port alu_op  out  4  ALU operation {funct7[5],funct3} encoding; 0000 add, 1000 sub.
REQ-014 SHALL have ports retire, illegal  out  1 each  one-cycle pulse on an instruction's final cycle; sticky illegal-instruction flag.
REQ-015 SHALL have port state  out  4  current state code, for debug.

Function
REQ-016 SHALL be Moore-style: outputs decode from state (plus opcode/funct/flags where stated); unlisted outputs are 0, selects 00, alu_op 0000.
REQ-017 SHALL use state codes IF=0 ID=1 EX_R=2 EX_I=3 LUI=4 AUIPC=5 WB_ALU=6 ADDR=7 MEM_RD=8 WB_LD=9 MEM_WR=10 BR=11 BR_TGT=12 JAL=13 JALR=14 TRAP=15.
REQ-018 IF SHALL assert mem_read; when mem_ready, it SHALL assert ir_write and pc_write (pc_sel 00) and go to ID; otherwise it SHALL stay in IF with both write enables 0.
REQ-019 ID SHALL dispatch by opcode: 0110011->EX_R, 0010011->EX_I, 0110111->LUI, 0010111->AUIPC, 0000011/0100011->ADDR, 1100011->BR, 1101111->JAL, 1100111->JALR, any other->TRAP.
REQ-020 EX_R SHALL drive A=rs1, B=rs2, alu_op={funct7[5],funct3}, then go to WB_ALU.
REQ-021 EX_I SHALL drive A=rs1, B=imm, and alu_op={funct7[5],funct3} if funct3=101, else {0,funct3}; then go to WB_ALU.
REQ-022 LUI SHALL drive A=zero, B=imm, add; AUIPC SHALL drive A=pc_old, B=imm, add; both then go to WB_ALU.
REQ-023 WB_ALU SHALL assert reg_write with wb_sel 00 and retire, then go to IF.
REQ-024 ADDR SHALL drive A=rs1, B=imm, add, then go to MEM_RD if opcode=0000011, else MEM_WR.
REQ-025 MEM_RD SHALL hold mem_read until mem_ready, then go to WB_LD; WB_LD SHALL assert reg_write with wb_sel 01 and retire, then go to IF.
REQ-026 MEM_WR SHALL hold mem_write until mem_ready; on that cycle it SHALL assert retire and go to IF.
REQ-027 BR SHALL drive A=rs1, B=rs2, sub, and evaluate taken by funct3: 000 zf, 001 !zf, 100 sf^of, 101 !(sf^of), 110 cf, 111 !cf; funct3 010/011 SHALL go to TRAP.
REQ-028 BR not-taken SHALL assert retire and go to IF; BR taken SHALL go to BR_TGT.
REQ-029 BR_TGT SHALL drive A=pc_old, B=imm, add, pc_write with pc_sel 01, and retire, then go to IF.
REQ-030 JAL SHALL drive A=pc_old, B=imm, add, pc_write with pc_sel 01, reg_write with wb_sel 10, and retire in one cycle, then go to IF.
REQ-031 JALR SHALL be the same as JAL except A=rs1 and pc_sel 10.
REQ-032 TRAP SHALL be absorbing until reset, with all enables 0; illegal SHALL be set on entry and hold at 1.
REQ-033 rd=x0 write suppression SHALL be left to the register file; this block asserts reg_write regardless of rd.

Reset
REQ-034 While rst_n=0, state SHALL be IF, illegal SHALL be 0, and every output enable, select, alu_op and retire SHALL be forced to 0, including mem_read.
REQ-035 Reset asserted mid-instruction SHALL abort it immediately with no further write enables; after release, the block SHALL restart at IF.

Verification
REQ-036 Bench SHALL cover: add (opcode 0110011, funct7 0000000, funct3 000), mem_ready=1 -> states 0,1,2,6; reg_write and retire in the 4th cycle only.
REQ-037 Bench SHALL cover: lw with mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles; WB_LD reg_write with wb_sel 01 in the following cycle.
REQ-038 Bench SHALL cover: beq with zf=1 -> BR then BR_TGT with pc_write=1, pc_sel 01; with zf=0 -> retire in BR, no pc_write.
REQ-039 Bench SHALL cover: srai (0010011, funct3 101, funct7 0100000) -> alu_op 1101; addi with funct7 bits set -> alu_op 0000.
REQ-040 Bench SHALL cover: opcode 1111111 -> ID then TRAP, illegal=1, all enables stay 0 for 10 cycles; rst_n pulse low -> illegal=0, state=0.
REQ-041 Bench SHALL cover: rst_n low during MEM_WR with mem_write=1 -> mem_write drops asynchronously before the next clock edge.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle RV32I control FSM driving datapath enables and selects
module cpu_ctrl_fsm #(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic       cf,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] pc_sel,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [3:0] alu_op,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_EX_I   = 4'd3,
        S_LUI    = 4'd4,
        S_AUIPC  = 4'd5,
        S_WB_ALU = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_WB_LD  = 4'd9,
        S_MEM_WR = 4'd10,
        S_BR     = 4'd11,
        S_BR_TGT = 4'd12,
        S_JAL    = 4'd13,
        S_JALR   = 4'd14,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_ALU    = 2'b01;
    localparam logic [1:0] PC_ALU_LO = 2'b10;
    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] A_RS1     = 2'b00;
    localparam logic [1:0] A_PC      = 2'b01;
    localparam logic [1:0] A_ZERO    = 2'b10;
    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_IMM     = 2'b01;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;

    state_t cur_state;
    state_t next_state;
    logic   illegal_q;
    logic   rdy;
    logic   br_taken;
    logic   br_bad;
    logic   unused_funct7;

    // Only funct7[5] participates in ALU op selection
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Memory handshake, optionally tied off for single-cycle memories
    assign rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    assign state   = cur_state;
    assign illegal = illegal_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= next_state;
        end
    end

    // Sticky illegal flag, set on the edge that enters TRAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (next_state == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Branch condition from the subtract flags of rs1 - rs2
    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (funct3)
            3'b000:  br_taken = zf;
            3'b001:  br_taken = !zf;
            3'b100:  br_taken = sf ^ of;
            3'b101:  br_taken = !(sf ^ of);
            3'b110:  br_taken = cf;
            3'b111:  br_taken = !cf;
            default: br_bad   = 1'b1;
        endcase
    end

    // Next-state and Moore output decode; reset forces every output low at once
    always_comb begin
        next_state = cur_state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pc_sel     = PC_PLUS4;
        wb_sel     = WB_ALU;
        alu_a_sel  = A_RS1;
        alu_b_sel  = B_RS2;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
        case (cur_state)
            S_IF: begin
                mem_read = 1'b1;
                if (rdy) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = S_ID;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_R:     next_state = S_EX_R;
                    OP_I:     next_state = S_EX_I;
                    OP_LUI:   next_state = S_LUI;
                    OP_AUIPC: next_state = S_AUIPC;
                    OP_LOAD:  next_state = S_ADDR;
                    OP_STORE: next_state = S_ADDR;
                    OP_BR:    next_state = S_BR;
                    OP_JAL:   next_state = S_JAL;
                    OP_JALR:  next_state = S_JALR;
                    default:  next_state = S_TRAP;
                endcase
            end
            S_EX_R: begin
                alu_op     = {funct7[5], funct3};
                next_state = S_WB_ALU;
            end
            S_EX_I: begin
                alu_b_sel  = B_IMM;
                // Only shifts (srli/srai) take the funct7 qualifier; other immediates carry imm bits there
                alu_op     = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
                next_state = S_WB_ALU;
            end
            S_LUI: begin
                alu_a_sel  = A_ZERO;
                alu_b_sel  = B_IMM;
                next_state = S_WB_ALU;
            end
            S_AUIPC: begin
                alu_a_sel  = A_PC;
                alu_b_sel  = B_IMM;
                next_state = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                wb_sel     = WB_ALU;
                retire     = 1'b1;
                next_state = S_IF;
            end
            S_ADDR: begin
                alu_b_sel  = B_IMM;
                next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                if (rdy) begin
                    next_state = S_WB_LD;
                end
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                wb_sel     = WB_MEM;
                retire     = 1'b1;
                next_state = S_IF;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                if (rdy) begin
                    retire     = 1'b1;
                    next_state = S_IF;
                end
            end
            S_BR: begin
                alu_op = ALU_SUB;
                if (br_bad) begin
                    next_state = S_TRAP;
                end else if (br_taken) begin
                    next_state = S_BR_TGT;
                end else begin
                    retire     = 1'b1;
                    next_state = S_IF;
                end
            end
            S_BR_TGT: begin
                alu_a_sel  = A_PC;
                alu_b_sel  = B_IMM;
                pc_write   = 1'b1;
                pc_sel     = PC_ALU;
                retire     = 1'b1;
                next_state = S_IF;
            end
            S_JAL: begin
                alu_a_sel  = A_PC;
                alu_b_sel  = B_IMM;
                pc_write   = 1'b1;
                pc_sel     = PC_ALU;
                reg_write  = 1'b1;
                wb_sel     = WB_PC;
                retire     = 1'b1;
                next_state = S_IF;
            end
            S_JALR: begin
                alu_a_sel  = A_RS1;
                alu_b_sel  = B_IMM;
                pc_write   = 1'b1;
                pc_sel     = PC_ALU_LO;
                reg_write  = 1'b1;
                wb_sel     = WB_PC;
                retire     = 1'b1;
                next_state = S_IF;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_IF;
            end
        endcase
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            pc_sel    = PC_PLUS4;
            wb_sel    = WB_ALU;
            alu_a_sel = A_RS1;
            alu_b_sel = B_RS2;
            alu_op    = ALU_ADD;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zf = 1'b0, sf = 1'b0, of = 1'b0, cf = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, ir_write, reg_write, mem_read, mem_write, retire, illegal;
    logic [1:0] pc_sel, wb_sel, alu_a_sel, alu_b_sel;
    logic [3:0] alu_op, state;

    logic       pc_write_nr, ir_write_nr, reg_write_nr, mem_read_nr, mem_write_nr, retire_nr, illegal_nr;
    logic [1:0] pc_sel_nr, wb_sel_nr, alu_a_sel_nr, alu_b_sel_nr;
    logic [3:0] alu_op_nr, state_nr;

    cpu_ctrl_fsm #(.USE_MEM_READY(1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zf(zf), .sf(sf), .of(of), .cf(cf), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .pc_sel(pc_sel), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .retire(retire), .illegal(illegal), .state(state)
    );

    cpu_ctrl_fsm #(.USE_MEM_READY(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zf(zf), .sf(sf), .of(of), .cf(cf), .mem_ready(mem_ready),
        .pc_write(pc_write_nr), .ir_write(ir_write_nr), .reg_write(reg_write_nr),
        .mem_read(mem_read_nr), .mem_write(mem_write_nr), .pc_sel(pc_sel_nr), .wb_sel(wb_sel_nr),
        .alu_a_sel(alu_a_sel_nr), .alu_b_sel(alu_b_sel_nr), .alu_op(alu_op_nr),
        .retire(retire_nr), .illegal(illegal_nr), .state(state_nr)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rgw, mrd, mwr;
        logic [1:0] pcs, wbs, as, bs;
        logic [3:0] aop;
        logic       ret, ill;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] fl;
        logic       mr;
        exp_t       e;
    } item_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] st;
        logic [3:0] aop;
        logic [1:0] as;
        logic [1:0] bs;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t q[$];
    logic [6:0] m_op;
    logic [2:0] m_f3;
    logic [6:0] m_f7;
    logic [3:0] m_fl;

    function automatic exp_t z(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.st = state; a.pcw = pc_write; a.irw = ir_write; a.rgw = reg_write;
        a.mrd = mem_read; a.mwr = mem_write; a.pcs = pc_sel; a.wbs = wb_sel;
        a.as = alu_a_sel; a.bs = alu_b_sel; a.aop = alu_op; a.ret = retire; a.ill = illegal;
        return a;
    endfunction

    task automatic check_vec(input string name, input exp_t got, input exp_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %06h want %06h", name, got, want);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [3:0] fl, input logic mr);
        @(negedge clk);
        opcode = op; funct3 = f3; funct7 = f7;
        {zf, sf, of, cf} = fl;
        mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_vec("reset_outputs", actual(), z(4'd0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put(input logic mr, input exp_t e);
        item_t it;
        it.op = m_op; it.f3 = m_f3; it.f7 = m_f7; it.fl = m_fl; it.mr = mr; it.e = e;
        q.push_back(it);
    endtask

    // Instruction-level reference: expected per-cycle outputs for one instruction,
    // with branch outcome decided from the compared operands themselves.
    task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b,
                               input int wf, input int wm, output logic trapped);
        exp_t e;
        logic [31:0] d;
        logic taken;
        logic bad;
        d = a - b;
        m_op = op; m_f3 = f3; m_f7 = f7;
        m_fl = {d == 32'd0, d[31], (a[31] != b[31]) && (d[31] != a[31]), a < b};
        trapped = 1'b0;
        for (int i = 0; i < wf; i++) begin
            e = z(4'd0); e.mrd = 1'b1; put(1'b0, e);
        end
        e = z(4'd0); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; put(1'b1, e);
        put(1'($urandom_range(0, 1)), z(4'd1));
        case (op)
            OP_R: begin
                e = z(4'd2); e.aop = {f7[5], f3}; put(1'($urandom_range(0, 1)), e);
            end
            OP_I: begin
                e = z(4'd3); e.bs = 2'b01;
                e.aop = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
                put(1'($urandom_range(0, 1)), e);
            end
            OP_LUI: begin
                e = z(4'd4); e.as = 2'b10; e.bs = 2'b01; put(1'($urandom_range(0, 1)), e);
            end
            OP_AUIPC: begin
                e = z(4'd5); e.as = 2'b01; e.bs = 2'b01; put(1'($urandom_range(0, 1)), e);
            end
            OP_LOAD, OP_STORE: begin
                e = z(4'd7); e.bs = 2'b01; put(1'($urandom_range(0, 1)), e);
                if (op == OP_LOAD) begin
                    for (int i = 0; i <= wm; i++) begin
                        e = z(4'd8); e.mrd = 1'b1; put(i == wm, e);
                    end
                    e = z(4'd9); e.rgw = 1'b1; e.wbs = 2'b01; e.ret = 1'b1;
                    put(1'($urandom_range(0, 1)), e);
                end else begin
                    for (int i = 0; i <= wm; i++) begin
                        e = z(4'd10); e.mwr = 1'b1; e.ret = (i == wm); put(i == wm, e);
                    end
                end
            end
            OP_BR: begin
                bad = 1'b0;
                taken = 1'b0;
                case (f3)
                    3'b000: taken = (a == b);
                    3'b001: taken = (a != b);
                    3'b100: taken = ($signed(a) < $signed(b));
                    3'b101: taken = ($signed(a) >= $signed(b));
                    3'b110: taken = (a < b);
                    3'b111: taken = (a >= b);
                    default: bad = 1'b1;
                endcase
                e = z(4'd11); e.aop = 4'b1000; e.ret = !bad && !taken;
                put(1'($urandom_range(0, 1)), e);
                if (bad) begin
                    trapped = 1'b1;
                end else if (taken) begin
                    e = z(4'd12); e.as = 2'b01; e.bs = 2'b01; e.pcw = 1'b1; e.pcs = 2'b01; e.ret = 1'b1;
                    put(1'($urandom_range(0, 1)), e);
                end
            end
            OP_JAL, OP_JALR: begin
                e = z(op == OP_JAL ? 4'd13 : 4'd14);
                e.as = (op == OP_JAL) ? 2'b01 : 2'b00; e.bs = 2'b01;
                e.pcw = 1'b1; e.pcs = (op == OP_JAL) ? 2'b01 : 2'b10;
                e.rgw = 1'b1; e.wbs = 2'b10; e.ret = 1'b1;
                put(1'($urandom_range(0, 1)), e);
            end
            default: trapped = 1'b1;
        endcase
        if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_AUIPC) begin
            e = z(4'd6); e.rgw = 1'b1; e.ret = 1'b1; put(1'($urandom_range(0, 1)), e);
        end
        if (trapped) begin
            for (int i = 0; i < 4; i++) begin
                e = z(4'd15); e.ill = 1'b1; put(1'($urandom_range(0, 1)), e);
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[13];
        exp_t  e;
        logic [6:0] ops[10];
        logic [6:0] bad_ops[4];
        logic [3:0] want_st[4];
        logic [1:0] want_rr[4];
        logic [31:0] a, b;
        logic tr;
        int   rd_cycles;

        tbl[0]  = '{"add",   OP_R,     3'b000, 7'b0000000, 4'd2,  4'b0000, 2'b00, 2'b00};
        tbl[1]  = '{"sub",   OP_R,     3'b000, 7'b0100000, 4'd2,  4'b1000, 2'b00, 2'b00};
        tbl[2]  = '{"sra",   OP_R,     3'b101, 7'b0100000, 4'd2,  4'b1101, 2'b00, 2'b00};
        tbl[3]  = '{"srai",  OP_I,     3'b101, 7'b0100000, 4'd3,  4'b1101, 2'b00, 2'b01};
        tbl[4]  = '{"addi7", OP_I,     3'b000, 7'b0100000, 4'd3,  4'b0000, 2'b00, 2'b01};
        tbl[5]  = '{"slti7", OP_I,     3'b010, 7'b1111111, 4'd3,  4'b0010, 2'b00, 2'b01};
        tbl[6]  = '{"lui",   OP_LUI,   3'b011, 7'b0100000, 4'd4,  4'b0000, 2'b10, 2'b01};
        tbl[7]  = '{"auipc", OP_AUIPC, 3'b111, 7'b0100000, 4'd5,  4'b0000, 2'b01, 2'b01};
        tbl[8]  = '{"lw",    OP_LOAD,  3'b010, 7'b0000000, 4'd7,  4'b0000, 2'b00, 2'b01};
        tbl[9]  = '{"sw",    OP_STORE, 3'b010, 7'b0100000, 4'd7,  4'b0000, 2'b00, 2'b01};
        tbl[10] = '{"beq",   OP_BR,    3'b000, 7'b0000000, 4'd11, 4'b1000, 2'b00, 2'b00};
        tbl[11] = '{"jal",   OP_JAL,   3'b101, 7'b0100000, 4'd13, 4'b0000, 2'b01, 2'b01};
        tbl[12] = '{"jalr",  OP_JALR,  3'b000, 7'b0000000, 4'd14, 4'b0000, 2'b00, 2'b01};

        // Table: dispatch and execute-cycle ALU control
        foreach (tbl[i]) begin
            do_reset();
            step(tbl[i].op, tbl[i].f3, tbl[i].f7, 4'b0000, 1'b1);
            step(tbl[i].op, tbl[i].f3, tbl[i].f7, 4'b0000, 1'b1);
            step(tbl[i].op, tbl[i].f3, tbl[i].f7, 4'b0000, 1'b1);
            check({"tbl_", tbl[i].name}, {state, alu_op, alu_a_sel, alu_b_sel},
                  {tbl[i].st, tbl[i].aop, tbl[i].as, tbl[i].bs});
        end

        // add: states 0,1,2,6 with writeback only in the fourth cycle
        want_st = '{4'd0, 4'd1, 4'd2, 4'd6};
        want_rr = '{2'b00, 2'b00, 2'b00, 2'b11};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(OP_R, 3'b000, 7'b0000000, 4'b0000, 1'b1);
            check($sformatf("add_cyc%0d", i), {state, reg_write, retire}, {want_st[i], want_rr[i]});
        end

        // lw with three wait cycles in MEM_RD
        do_reset();
        step(OP_LOAD, 3'b010, 7'd0, 4'd0, 1'b1);
        step(OP_LOAD, 3'b010, 7'd0, 4'd0, 1'b1);
        step(OP_LOAD, 3'b010, 7'd0, 4'd0, 1'b1);
        rd_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            step(OP_LOAD, 3'b010, 7'd0, 4'd0, i == 3);
            if (state == 4'd8 && mem_read) rd_cycles++;
        end
        check("lw_mem_read_cycles", rd_cycles, 4);
        step(OP_LOAD, 3'b010, 7'd0, 4'd0, 1'b0);
        check("lw_wb_ld", {state, reg_write, wb_sel, retire}, {4'd9, 1'b1, 2'b01, 1'b1});

        // beq taken and not taken
        do_reset();
        step(OP_BR, 3'b000, 7'd0, 4'b1000, 1'b1);
        step(OP_BR, 3'b000, 7'd0, 4'b1000, 1'b1);
        step(OP_BR, 3'b000, 7'd0, 4'b1000, 1'b1);
        check("beq_t_br", {state, pc_write, retire}, {4'd11, 1'b0, 1'b0});
        step(OP_BR, 3'b000, 7'd0, 4'b1000, 1'b1);
        check("beq_t_tgt", {state, pc_write, pc_sel, retire}, {4'd12, 1'b1, 2'b01, 1'b1});
        do_reset();
        step(OP_BR, 3'b000, 7'd0, 4'b0000, 1'b1);
        step(OP_BR, 3'b000, 7'd0, 4'b0000, 1'b1);
        step(OP_BR, 3'b000, 7'd0, 4'b0000, 1'b1);
        check("beq_nt_br", {state, pc_write, retire}, {4'd11, 1'b0, 1'b1});
        step(OP_BR, 3'b000, 7'd0, 4'b0000, 1'b0);
        check("beq_nt_next", {state, pc_write}, {4'd0, 1'b0});

        // Illegal opcode: absorbing TRAP, then cleared by reset
        do_reset();
        step(7'b1111111, 3'b000, 7'd0, 4'd0, 1'b1);
        step(7'b1111111, 3'b000, 7'd0, 4'd0, 1'b1);
        check("trap_id", {state, illegal}, {4'd1, 1'b0});
        e = z(4'd15);
        e.ill = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(7'b1111111, 3'($urandom), 7'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            check_vec($sformatf("trap_hold%0d", i), actual(), e);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_vec("trap_reset", actual(), z(4'd0));
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        e = z(4'd0);
        e.mrd = 1'b1;
        check_vec("trap_after_release", actual(), e);

        // Reset during MEM_WR drops mem_write before the next clock edge
        do_reset();
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b1);
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b1);
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b1);
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b0);
        check("sw_mem_wr", {state, mem_write, retire}, {4'd10, 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("sw_async_drop", mem_write, 1'b0);
        check_vec("sw_async_all", actual(), z(4'd0));
        @(negedge clk);
        rst_n = 1'b1;

        // USE_MEM_READY=0 instance proceeds with mem_ready held low
        do_reset();
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b0);
        check("nr_id", state_nr, 4'd1);
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b0);
        step(OP_STORE, 3'b010, 7'd0, 4'd0, 1'b0);
        check("nr_mem_wr", {state_nr, mem_write_nr, retire_nr}, {4'd10, 1'b1, 1'b1});

        // Randomized instruction streams against the instruction-level model
        ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, 7'b1111111};
        bad_ops = '{7'b0000000, 7'b1110011, 7'b1111111, 7'b0001111};
        for (int r = 0; r < 40; r++) begin
            do_reset();
            q.delete();
            for (int k = 0; k < 6; k++) begin
                int idx;
                logic [6:0] op;
                idx = $urandom_range(0, 9);
                op = (idx == 9) ? bad_ops[$urandom_range(0, 3)] : ops[idx];
                a = $urandom;
                b = ($urandom_range(0, 2) == 0) ? a : $urandom;
                model_instr(op, 3'($urandom), 7'($urandom), a, b,
                            $urandom_range(0, 3), $urandom_range(0, 3), tr);
                if (tr) break;
            end
            foreach (q[i]) begin
                step(q[i].op, q[i].f3, q[i].f7, q[i].fl, q[i].mr);
                check_vec($sformatf("rand_r%0d_c%0d", r, i), actual(), q[i].e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
